ocp3_nic_card_responder: RTL and testbench
==========================================

# ocp3_nic_card_responder

Card-side counterpart of the baseboard OCP3 NIC power sequencer; it sits in the NIC/riser CPLD. It decodes the baseboard's AUX_PWR_EN, MAIN_PWR_EN and PERST_N, enables the card's local AUX and MAIN regulators, and returns NIC_PWR_GOOD. It also gates the ASIC reset, enforces regulator power-good timeouts and latches sticky fault flags for BMC readout.

## Interface
Parameters:
- AUX_PG_TIMEOUT_MS, 16'd100, max time from AUX rail enable to iPG_AUX_RAILS
- MAIN_PG_TIMEOUT_MS, 16'd100, max time from MAIN rail enable to iPG_MAIN_RAILS
- PWRGD_DLY_MS, 16'd5, delay from AUX rails good to oNIC_PWR_GOOD assertion

Ports:
- iClk  in  1  module clock
- iRst_n  in  1  reset, asynchronous, active-low; clock iClk
- iTick_1ms  in  1  single-cycle strobe every 1 ms, synchronous to iClk
- iAUX_PWR_EN, iMAIN_PWR_EN, iPERST_N  in  1 each  baseboard controls, async, 2-FF synchronized
- iPG_AUX_RAILS, iPG_MAIN_RAILS  in  1 each  local regulator PGs, async, 2-FF synchronized
- iFault_Clear  in  1  synchronous pulse, clears sticky flags and exits FAULT
- oEN_AUX_RAILS, oEN_MAIN_RAILS  out  1 each  local regulator enables
- oNIC_PWR_GOOD  out  1  returned to the baseboard
- oNIC_RST_N  out  1  ASIC reset
- oFSM_state  out  4  current state
- oFLT_AUX_TIMEOUT, oFLT_MAIN_TIMEOUT, oFLT_PG_LOSS, oFLT_PERST_EARLY  out  1 each  sticky faults, active-high

## Operation
- States:
  - OFF 4'h0
  - AUX_RAMP 4'h1
  - AUX_ON 4'h2
  - MAIN_RAMP 4'h3
  - MAIN_ON 4'h4
  - MAIN_DOWN 4'h5
  - FAULT 4'hF
- **ms counter:** 16-bit; increments on iTick_1ms; saturates at 16'hFFFF; cleared on every state change. "Elapsed N" means count >= N.
- **OFF:** all enables 0, PWR_GOOD 0, RST_N 0. aux_en=1 -> AUX_RAMP, EN_AUX=1.
- **AUX_RAMP:**
  - pg_aux=1 -> AUX_ON.
  - Elapsed AUX_PG_TIMEOUT_MS with pg_aux=0 -> FAULT, set FLT_AUX_TIMEOUT.
- **AUX_ON:**
  - PWR_GOOD set once elapsed PWRGD_DLY_MS.
  - main_en=1 and PWR_GOOD=1 -> MAIN_RAMP: EN_MAIN=1, PWR_GOOD=0.
  - pg_aux=0 -> FAULT, set FLT_PG_LOSS.
- **MAIN_RAMP:**
  - pg_main=1 -> MAIN_ON, PWR_GOOD=1.
  - main_en=0 -> MAIN_DOWN.
  - Elapsed MAIN_PG_TIMEOUT_MS -> FAULT, set FLT_MAIN_TIMEOUT.
- **MAIN_ON:**
  - RST_N follows perst_n.
  - main_en=0 -> MAIN_DOWN.
  - pg_aux=0 or pg_main=0 -> FAULT, set FLT_PG_LOSS.
- **MAIN_DOWN:** RST_N=0, EN_MAIN=0, PWR_GOOD held 1. pg_main=0 -> AUX_ON; PWR_GOOD stays 1, no PWRGD_DLY_MS re-wait.
- **FAULT:**
  - All enables 0, PWR_GOOD 0, RST_N 0.
  - iFault_Clear with aux_en=0 -> OFF, flags cleared.
  - iFault_Clear with aux_en=1 clears flags only; the block stays in FAULT.
  - aux_en=0 by itself does not exit FAULT.
- **aux_en=0 in any state except FAULT** -> OFF next cycle. This has priority over every other transition evaluated in the same cycle.
- **PERST check:** perst_n=1 while the state is not MAIN_ON sets FLT_PERST_EARLY. This is a warning only: no state change, and RST_N stays 0.
- **Fault flags:** sticky until iFault_Clear. If iFault_Clear and a new fault event occur in the same cycle, the fault is set (set wins).

## Timing
- **Reset values:**
  - All outputs 0.
  - oFSM_state = 4'h0.
  - Counter 0.
  - Synchronizer flops 0.
- **Input latency:** 2 cycles of synchronization plus 1 registered-output cycle, i.e. 3 iClk from an async input edge to the output response.
- **State outputs** are registered and update in the same cycle as the state register.
- **PWR_GOOD in AUX_ON:** asserts on the first cycle with count >= PWRGD_DLY_MS. With PWRGD_DLY_MS=0 it asserts on the cycle after AUX_ON entry.
- **Timeout resolution:** -1/+0 ms, because the first tick after entry may arrive immediately.
- **iTick_1ms in the same cycle as a state change:** the counter clears and the tick is dropped.

## Test plan
- **Normal up:** aux_en=1, PG_AUX after 3 ms, PWRGD_DLY_MS=5 -> EN_AUX 3 cycles after aux_en; PWR_GOOD asserted at 5 ms after AUX_ON. Then main_en=1, PG_MAIN after 10 ms -> PWR_GOOD low for the 10 ms, then high in MAIN_ON. Then perst_n=1 -> RST_N=1 after 3 cycles.
- **Normal down:** from MAIN_ON, main_en=0 -> RST_N=0, EN_MAIN=0, PWR_GOOD stays 1; PG_MAIN drops -> AUX_ON. Then aux_en=0 -> OFF with all outputs 0.
- **AUX timeout:** aux_en=1, PG_AUX never rises -> FAULT (4'hF) after 100 ms, FLT_AUX_TIMEOUT=1, EN_AUX=0. iFault_Clear while aux_en=1 -> flag clears, state stays FAULT. Drop aux_en, then pulse iFault_Clear -> OFF.
- **PG loss in MAIN_ON:** drop PG_MAIN -> FAULT, FLT_PG_LOSS=1, all enables 0 within 3 cycles.
- **Early PERST:** perst_n=1 while in AUX_ON -> FLT_PERST_EARLY=1, RST_N stays 0, state unchanged.
- **Priority and reset:** aux_en=0 in the same cycle PG_MAIN rises in MAIN_RAMP -> next state OFF. iRst_n asserted mid-MAIN_ON -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/ocp3_nic_card_responder.sv
// ocp3_nic_card_responder: card-side OCP3 NIC power sequencer that answers the baseboard power controls
module ocp3_nic_card_responder #(
   parameter logic [15:0] AUX_PG_TIMEOUT_MS  = 16'd100,
   parameter logic [15:0] MAIN_PG_TIMEOUT_MS = 16'd100,
   parameter logic [15:0] PWRGD_DLY_MS       = 16'd5
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iTick_1ms,
   input  logic       iAUX_PWR_EN,
   input  logic       iMAIN_PWR_EN,
   input  logic       iPERST_N,
   input  logic       iPG_AUX_RAILS,
   input  logic       iPG_MAIN_RAILS,
   input  logic       iFault_Clear,
   output logic       oEN_AUX_RAILS,
   output logic       oEN_MAIN_RAILS,
   output logic       oNIC_PWR_GOOD,
   output logic       oNIC_RST_N,
   output logic [3:0] oFSM_state,
   output logic       oFLT_AUX_TIMEOUT,
   output logic       oFLT_MAIN_TIMEOUT,
   output logic       oFLT_PG_LOSS,
   output logic       oFLT_PERST_EARLY
);
   typedef enum logic [3:0] {
      OFF       = 4'h0,
      AUX_RAMP  = 4'h1,
      AUX_ON    = 4'h2,
      MAIN_RAMP = 4'h3,
      MAIN_ON   = 4'h4,
      MAIN_DOWN = 4'h5,
      FAULT     = 4'hF
   } state_t;
   state_t      state, nxt;
   logic [4:0]  sync1, sync2;
   logic [15:0] cnt;
   logic [3:0]  flt, flt_set;
   logic        aux_en, main_en, perst_n, pg_aux, pg_main;
   logic        en_aux, en_main, pwr_good, rst_n;
   assign {perst_n, pg_main, pg_aux, main_en, aux_en} = sync2;
   assign oEN_AUX_RAILS  = en_aux;
   assign oEN_MAIN_RAILS = en_main;
   assign oNIC_PWR_GOOD  = pwr_good;
   assign oNIC_RST_N     = rst_n;
   assign oFSM_state     = state;
   assign {oFLT_AUX_TIMEOUT, oFLT_MAIN_TIMEOUT, oFLT_PG_LOSS, oFLT_PERST_EARLY} = flt;
   // Two-flop synchronizers for the baseboard controls and local regulator power-goods
   always_ff @(posedge iClk or negedge iRst_n)
      if (!iRst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {iPERST_N, iPG_MAIN_RAILS, iPG_AUX_RAILS, iMAIN_PWR_EN, iAUX_PWR_EN};
         sync2 <= sync1;
      end
   // Next-state decode and fault events; losing aux_en overrides everything outside FAULT
   always_comb begin
      nxt     = state;
      flt_set = '0;
      case (state)
         OFF:       if (aux_en) nxt = AUX_RAMP;
         AUX_RAMP:  if (pg_aux) nxt = AUX_ON;
                    else if (cnt >= AUX_PG_TIMEOUT_MS) begin
                       nxt        = FAULT;
                       flt_set[3] = 1'b1;
                    end
         AUX_ON:    if (!pg_aux) begin
                       nxt        = FAULT;
                       flt_set[1] = 1'b1;
                    end else if (main_en && pwr_good) nxt = MAIN_RAMP;
         MAIN_RAMP: if (pg_main) nxt = MAIN_ON;
                    else if (!main_en) nxt = MAIN_DOWN;
                    else if (cnt >= MAIN_PG_TIMEOUT_MS) begin
                       nxt        = FAULT;
                       flt_set[2] = 1'b1;
                    end
         MAIN_ON:   if (!main_en) nxt = MAIN_DOWN;
                    else if (!pg_aux || !pg_main) begin
                       nxt        = FAULT;
                       flt_set[1] = 1'b1;
                    end
         MAIN_DOWN: if (!pg_main) nxt = AUX_ON;
         FAULT:     if (iFault_Clear && !aux_en) nxt = OFF;
         default:   nxt = OFF;
      endcase
      if (!aux_en && state != FAULT) begin
         nxt          = OFF;
         flt_set[3:1] = '0;
      end
      flt_set[0] = perst_n && (state != MAIN_ON);
   end
   // State, ms counter (cleared on every state change), registered outputs and sticky flags (set beats clear)
   always_ff @(posedge iClk or negedge iRst_n)
      if (!iRst_n) begin
         state    <= OFF;
         cnt      <= '0;
         en_aux   <= 1'b0;
         en_main  <= 1'b0;
         pwr_good <= 1'b0;
         rst_n    <= 1'b0;
         flt      <= '0;
      end else begin
         state    <= nxt;
         cnt      <= (nxt != state) ? 16'd0 : (iTick_1ms && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
         en_aux   <= nxt inside {AUX_RAMP, AUX_ON, MAIN_RAMP, MAIN_ON, MAIN_DOWN};
         en_main  <= nxt inside {MAIN_RAMP, MAIN_ON};
         rst_n    <= (nxt == MAIN_ON) && perst_n;
         pwr_good <= (nxt == MAIN_ON) || (nxt == MAIN_DOWN) ||
                     ((nxt == AUX_ON) && (pwr_good || (state == AUX_ON && cnt >= PWRGD_DLY_MS)));
         flt      <= (iFault_Clear ? 4'h0 : flt) | flt_set;
      end
endmodule

// File: tb/tb_ocp3_nic_card_responder.sv
// tb_ocp3_nic_card_responder: randomized scenarios checked through an expected-change scoreboard
module tb_ocp3_nic_card_responder;
   localparam int MS  = 20;
   localparam int DLY = 5;
   localparam int TO  = 100;
   logic iClk = 0, iRst_n = 0, iTick_1ms = 0;
   logic iAUX_PWR_EN = 0, iMAIN_PWR_EN = 0, iPERST_N = 0;
   logic iPG_AUX_RAILS = 0, iPG_MAIN_RAILS = 0, iFault_Clear = 0;
   logic oEN_AUX_RAILS, oEN_MAIN_RAILS, oNIC_PWR_GOOD, oNIC_RST_N;
   logic [3:0] oFSM_state;
   logic oFLT_AUX_TIMEOUT, oFLT_MAIN_TIMEOUT, oFLT_PG_LOSS, oFLT_PERST_EARLY;
   int cyc = 0, total = 0, bad = 0, tick_ph = 0, t_mark = 0;
   logic [3:0]  m_state = 4'h0;
   logic [3:0]  m_flags = 4'h0;
   logic        m_pg = 0, m_perst = 0;
   logic [11:0] m_last = 12'h0;
   typedef struct {
      string       name;
      logic [11:0] v;
      int          lo;
      int          hi;
   } exp_t;
   exp_t q[$];

   ocp3_nic_card_responder #(
      .AUX_PG_TIMEOUT_MS(16'(TO)), .MAIN_PG_TIMEOUT_MS(16'(TO)), .PWRGD_DLY_MS(16'(DLY))
   ) dut (
      .iClk(iClk), .iRst_n(iRst_n), .iTick_1ms(iTick_1ms),
      .iAUX_PWR_EN(iAUX_PWR_EN), .iMAIN_PWR_EN(iMAIN_PWR_EN), .iPERST_N(iPERST_N),
      .iPG_AUX_RAILS(iPG_AUX_RAILS), .iPG_MAIN_RAILS(iPG_MAIN_RAILS), .iFault_Clear(iFault_Clear),
      .oEN_AUX_RAILS(oEN_AUX_RAILS), .oEN_MAIN_RAILS(oEN_MAIN_RAILS),
      .oNIC_PWR_GOOD(oNIC_PWR_GOOD), .oNIC_RST_N(oNIC_RST_N), .oFSM_state(oFSM_state),
      .oFLT_AUX_TIMEOUT(oFLT_AUX_TIMEOUT), .oFLT_MAIN_TIMEOUT(oFLT_MAIN_TIMEOUT),
      .oFLT_PG_LOSS(oFLT_PG_LOSS), .oFLT_PERST_EARLY(oFLT_PERST_EARLY)
   );

   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;

   function automatic logic [11:0] dut_vec();
      return {oFSM_state, oEN_AUX_RAILS, oEN_MAIN_RAILS, oNIC_PWR_GOOD, oNIC_RST_N,
              oFLT_AUX_TIMEOUT, oFLT_MAIN_TIMEOUT, oFLT_PG_LOSS, oFLT_PERST_EARLY};
   endfunction

   // expected outputs from the abstract state: which rails a state powers, reset only released in MAIN_ON
   function automatic logic [11:0] mvec();
      logic ea, em, rn;
      ea = m_state inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
      em = m_state inside {4'h3, 4'h4};
      rn = (m_state == 4'h4) && m_perst;
      return {m_state, ea, em, m_pg, rn, m_flags};
   endfunction

   // a ms-timed event after entry at cycle e with threshold n ms lands in this window
   function automatic int wlo(input int e, input int n);
      return e + (n - 1) * MS + 2;
   endfunction
   function automatic int whi(input int e, input int n);
      return e + n * MS + 1;
   endfunction

   task automatic at_edge();
      @(posedge iClk);
      #1;
   endtask

   task automatic expect_chg(input string name, input int lo, input int hi);
      exp_t e;
      if (mvec() != m_last) begin
         e.name = name;
         e.v    = mvec();
         e.lo   = lo;
         e.hi   = hi;
         q.push_back(e);
         m_last = e.v;
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge iClk);
         n++;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s: change never seen within %0d cycles, wanted %h", q[0].name, budget, q[0].v);
         q.delete();
      end
      repeat (3) @(posedge iClk);
   endtask

   task automatic wait_ms(input int lo_ms, input int hi_ms);
      repeat ($urandom_range(hi_ms * MS, lo_ms * MS)) @(posedge iClk);
   endtask

   task automatic bring_aux();
      int ta;
      at_edge();
      iAUX_PWR_EN = 1;
      m_state = 4'h1;
      expect_chg("aux_ramp", cyc + 3, cyc + 3);
      drain(10);
      wait_ms(1, 5);
      at_edge();
      iPG_AUX_RAILS = 1;
      m_state = 4'h2;
      ta = cyc + 3;
      expect_chg("aux_on", ta, ta);
      m_pg = 1;
      expect_chg("pwr_good_dly", wlo(ta, DLY), whi(ta, DLY));
      drain((DLY + 1) * MS + 10);
   endtask

   task automatic bring_ramp();
      bring_aux();
      at_edge();
      iMAIN_PWR_EN = 1;
      m_state = 4'h3;
      m_pg = 0;
      t_mark = cyc + 3;
      expect_chg("main_ramp", t_mark, t_mark);
      drain(10);
   endtask

   task automatic bring_main();
      bring_ramp();
      wait_ms(1, 20);
      at_edge();
      iPG_MAIN_RAILS = 1;
      m_state = 4'h4;
      m_pg = 1;
      expect_chg("main_on", cyc + 3, cyc + 3);
      drain(10);
   endtask

   task automatic shutdown();
      at_edge();
      {iAUX_PWR_EN, iMAIN_PWR_EN, iPG_AUX_RAILS, iPG_MAIN_RAILS, iPERST_N} = '0;
      m_state = 4'h0;
      m_pg = 0;
      m_perst = 0;
      expect_chg("off", cyc + 3, cyc + 3);
      drain(10);
   endtask

   task automatic fault_exit();
      at_edge();
      {iAUX_PWR_EN, iMAIN_PWR_EN, iPG_AUX_RAILS, iPG_MAIN_RAILS, iPERST_N} = '0;
      m_perst = 0;
      repeat (5) @(posedge iClk);
      at_edge();
      iFault_Clear = 1;
      m_state = 4'h0;
      m_flags = 4'h0;
      expect_chg("fault_exit", cyc + 1, cyc + 1);
      at_edge();
      iFault_Clear = 0;
      drain(5);
   endtask

   // 1 ms strobe at a random phase
   initial begin
      tick_ph = $urandom_range(MS - 1, 0);
      forever begin
         at_edge();
         iTick_1ms = (cyc % MS == tick_ph);
      end
   end

   // monitor: every output change must match the next expected change, inside its cycle window
   initial begin
      logic [11:0] prev, cur;
      exp_t e;
      prev = '0;
      forever begin
         @(negedge iClk);
         cur = dut_vec();
         if (cur !== prev) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change: got %h at cycle %0d, wanted no change from %h", cur, cyc, prev);
            end else begin
               e = q.pop_front();
               if (cur !== e.v || cyc < e.lo || cyc > e.hi) begin
                  bad++;
                  $display("FAIL %s: got %h at cycle %0d, wanted %h in cycles [%0d,%0d]",
                           e.name, cur, cyc, e.v, e.lo, e.hi);
               end
            end
            prev = cur;
         end
      end
   end

   initial begin
      repeat (3) @(posedge iClk);
      #1;
      total++;
      if (dut_vec() !== 12'h0) begin
         bad++;
         $display("FAIL reset_state: got %h, wanted 000", dut_vec());
      end
      at_edge();
      iRst_n = 1;
      repeat (5) @(posedge iClk);
      // normal power up, PERST release, and orderly power down
      for (int k = 0; k < 2; k++) begin
         bring_main();
         at_edge();
         iPERST_N = 1;
         m_perst = 1;
         expect_chg("rst_release", cyc + 3, cyc + 3);
         drain(10);
         wait_ms(1, 3);
         at_edge();
         iPERST_N = 0;
         m_perst = 0;
         expect_chg("rst_assert", cyc + 3, cyc + 3);
         drain(10);
         at_edge();
         iMAIN_PWR_EN = 0;
         m_state = 4'h5;
         expect_chg("main_down", cyc + 3, cyc + 3);
         drain(10);
         wait_ms(0, 2);
         at_edge();
         iPG_MAIN_RAILS = 0;
         m_state = 4'h2;
         expect_chg("back_aux_on", cyc + 3, cyc + 3);
         drain(10);
         wait_ms(1, 2);
         shutdown();
      end
      // AUX regulator never comes up
      at_edge();
      iAUX_PWR_EN = 1;
      m_state = 4'h1;
      t_mark = cyc + 3;
      expect_chg("aux_ramp", t_mark, t_mark);
      m_state = 4'hF;
      m_flags[3] = 1;
      expect_chg("aux_timeout", wlo(t_mark, TO), whi(t_mark, TO));
      drain((TO + 1) * MS + 20);
      at_edge();
      iFault_Clear = 1;
      m_flags = 4'h0;
      expect_chg("clear_stays_fault", cyc + 1, cyc + 1);
      at_edge();
      iFault_Clear = 0;
      drain(5);
      at_edge();
      iAUX_PWR_EN = 0;
      repeat (6) @(posedge iClk);
      at_edge();
      iFault_Clear = 1;
      m_state = 4'h0;
      expect_chg("clear_to_off", cyc + 1, cyc + 1);
      at_edge();
      iFault_Clear = 0;
      drain(5);
      // MAIN power-good lost while running
      bring_main();
      at_edge();
      iPG_MAIN_RAILS = 0;
      m_state = 4'hF;
      m_pg = 0;
      m_flags[1] = 1;
      expect_chg("pg_loss", cyc + 3, cyc + 3);
      drain(10);
      fault_exit();
      // PERST released too early is only a warning
      bring_aux();
      at_edge();
      iPERST_N = 1;
      m_perst = 1;
      m_flags[0] = 1;
      expect_chg("perst_early", cyc + 3, cyc + 3);
      drain(10);
      at_edge();
      iPERST_N = 0;
      m_perst = 0;
      repeat (4) @(posedge iClk);
      at_edge();
      iFault_Clear = 1;
      m_flags = 4'h0;
      expect_chg("perst_flag_clear", cyc + 1, cyc + 1);
      at_edge();
      iFault_Clear = 0;
      drain(5);
      shutdown();
      // aux_en loss beats PG_MAIN arrival in the same cycle
      bring_ramp();
      at_edge();
      iAUX_PWR_EN = 0;
      iPG_MAIN_RAILS = 1;
      m_state = 4'h0;
      m_pg = 0;
      expect_chg("priority_off", cyc + 3, cyc + 3);
      drain(10);
      shutdown();
      // MAIN regulator never comes up
      bring_ramp();
      m_state = 4'hF;
      m_flags[2] = 1;
      expect_chg("main_timeout", wlo(t_mark, TO), whi(t_mark, TO));
      drain((TO + 1) * MS + 20);
      fault_exit();
      // asynchronous reset in the middle of MAIN_ON
      bring_main();
      at_edge();
      #2;
      m_state = 4'h0;
      m_pg = 0;
      m_flags = 4'h0;
      m_perst = 0;
      expect_chg("async_reset", cyc, cyc);
      iRst_n = 0;
      #1;
      total++;
      if (dut_vec() !== 12'h0) begin
         bad++;
         $display("FAIL async_reset_now: got %h, wanted 000", dut_vec());
      end
      {iAUX_PWR_EN, iMAIN_PWR_EN, iPG_AUX_RAILS, iPG_MAIN_RAILS, iPERST_N} = '0;
      drain(5);
      at_edge();
      iRst_n = 1;
      repeat (10) @(posedge iClk);
      drain(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
